// File: rtl/map_ss_seq.sv
// Save-state sequencer: walks mapper state bytes 0..SS_LEN-1 out to state memory (save) or back in (load).
// Optional macro SS_CHKSUM_EN appends an 8-bit wrapping checksum access at mem_addr 9'h100.
module map_ss_seq #(
  parameter int SS_LEN    = 128,
  parameter int WE_HOLD   = 4,
  parameter int RD_SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       save_req,
  input  logic       load_req,
  output logic       busy,
  output logic       done,
  output logic       ss_act,
  output logic       ss_we,
  output logic [7:0] ss_addr,
  output logic [7:0] ss_wdat,
  input  logic [7:0] ss_rdat,
  output logic [8:0] mem_addr,
  output logic [7:0] mem_wdat,
  output logic       mem_we,
  output logic       mem_re,
  input  logic [7:0] mem_rdat,
  input  logic       mem_ack,
  output logic       chk_err
);

  // Memory handshake: mem_we/mem_re is a held request with mem_addr/mem_wdat stable until the
  // one-cycle mem_ack; the request drops on the edge that samples mem_ack, mem_rdat valid with ack.
  typedef enum logic [3:0] {
    IDLE, S_SET, S_WR, L_REQ, L_WR, L_GAP, NEXT, S_CHK, L_CHK, DONE
  } state_t;

  localparam logic [7:0] LAST = 8'(SS_LEN - 1);

  state_t      state;
  logic        is_load;
  logic [7:0]  idx;
  logic [15:0] cnt;
  logic        accept;
  logic        settle_done;

  assign accept      = (state == IDLE) && (save_req || load_req);
  assign settle_done = (state == S_SET) && (cnt == 16'(RD_SETTLE - 1));

`ifdef SS_CHKSUM_EN
  logic [7:0] sum;

  always_ff @(posedge clk) begin
    if (rst) begin
      sum     <= 8'd0;
      chk_err <= 1'b0;
    end else if (accept) begin
      sum     <= 8'd0;
      chk_err <= 1'b0;
    end else if (settle_done) begin
      sum <= sum + ss_rdat;
    end else if (state == L_REQ && mem_ack) begin
      sum <= sum + mem_rdat;
    end else if (state == L_CHK && mem_ack) begin
      chk_err <= (mem_rdat != sum);
    end
  end
`else
  assign chk_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      is_load  <= 1'b0;
      idx      <= 8'd0;
      cnt      <= 16'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      ss_act   <= 1'b0;
      ss_we    <= 1'b0;
      ss_addr  <= 8'd0;
      ss_wdat  <= 8'd0;
      mem_addr <= 9'd0;
      mem_wdat <= 8'd0;
      mem_we   <= 1'b0;
      mem_re   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            busy   <= 1'b1;
            ss_act <= 1'b1;
            idx    <= 8'd0;
            cnt    <= 16'd0;
            if (save_req) begin
              is_load <= 1'b0;
              ss_addr <= 8'd0;
              state   <= S_SET;
            end else begin
              is_load  <= 1'b1;
              mem_re   <= 1'b1;
              mem_addr <= 9'd0;
              state    <= L_REQ;
            end
          end
        end
        S_SET: begin
          if (settle_done) begin
            cnt      <= 16'd0;
            mem_wdat <= ss_rdat;
            mem_we   <= 1'b1;
            mem_addr <= {1'b0, idx};
            state    <= S_WR;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_WR: begin
          if (mem_ack) begin
            mem_we <= 1'b0;
            state  <= NEXT;
          end
        end
        L_REQ: begin
          if (mem_ack) begin
            mem_re  <= 1'b0;
            ss_wdat <= mem_rdat;
            ss_addr <= idx;
            ss_we   <= 1'b1;
            cnt     <= 16'd0;
            state   <= L_WR;
          end
        end
        L_WR: begin
          if (cnt == 16'(WE_HOLD - 1)) begin
            ss_we <= 1'b0;
            state <= L_GAP;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        L_GAP: state <= NEXT;
        NEXT: begin
          if (idx == LAST) begin
`ifdef SS_CHKSUM_EN
            mem_addr <= 9'h100;
            if (is_load) begin
              mem_re <= 1'b1;
              state  <= L_CHK;
            end else begin
              mem_we   <= 1'b1;
              mem_wdat <= sum;
              state    <= S_CHK;
            end
`else
            busy     <= 1'b0;
            ss_act   <= 1'b0;
            done     <= 1'b1;
            idx      <= 8'd0;
            mem_addr <= 9'd0;
            state    <= DONE;
`endif
          end else begin
            idx <= idx + 8'd1;
            cnt <= 16'd0;
            if (is_load) begin
              mem_re   <= 1'b1;
              mem_addr <= {1'b0, idx + 8'd1};
              state    <= L_REQ;
            end else begin
              ss_addr <= idx + 8'd1;
              state   <= S_SET;
            end
          end
        end
        S_CHK, L_CHK: begin
          if (mem_ack) begin
            mem_we   <= 1'b0;
            mem_re   <= 1'b0;
            busy     <= 1'b0;
            ss_act   <= 1'b0;
            done     <= 1'b1;
            idx      <= 8'd0;
            mem_addr <= 9'd0;
            state    <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_map_ss_seq.sv
// Bench for map_ss_seq: mapper and state-memory models, table of save/load transfers, reset corner.
module tb_map_ss_seq;
  localparam int SS_LEN    = 128;
  localparam int WE_HOLD   = 4;
  localparam int RD_SETTLE = 1;
`ifdef SS_CHKSUM_EN
  localparam bit CHK_ON = 1'b1;
`else
  localparam bit CHK_ON = 1'b0;
`endif

  logic       clk = 1'b0, rst = 1'b1, save_req = 1'b0, load_req = 1'b0;
  logic       busy, done, ss_act, ss_we, mem_we, mem_re, chk_err;
  logic       mem_ack = 1'b0;
  logic [7:0] ss_addr, ss_wdat, ss_rdat, mem_wdat;
  logic [7:0] mem_rdat = 8'd0;
  logic [8:0] mem_addr;

  logic [7:0] map_state[256];
  logic [7:0] mem[512];
  logic [16:0] wr_log[$], map_log[$], exp_q[$], exp_m[$];
  logic [8:0]  rd_log[$], exp_rd[$];

  int n_cmp = 0, n_err = 0;
  int ack_lo = 0, ack_hi = 0, hold_addr = -1;

  typedef struct {
    bit do_save; bit do_load; int pattern; int ack_lo; int ack_hi;
    int inject; bit corrupt; bit exp_chk;
  } vec_t;
  vec_t vecs[7];

  assign ss_rdat = map_state[ss_addr];

  map_ss_seq #(.SS_LEN(SS_LEN), .WE_HOLD(WE_HOLD), .RD_SETTLE(RD_SETTLE)) dut (
    .clk(clk), .rst(rst), .save_req(save_req), .load_req(load_req),
    .busy(busy), .done(done), .ss_act(ss_act), .ss_we(ss_we),
    .ss_addr(ss_addr), .ss_wdat(ss_wdat), .ss_rdat(ss_rdat),
    .mem_addr(mem_addr), .mem_wdat(mem_wdat), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdat(mem_rdat), .mem_ack(mem_ack), .chk_err(chk_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pat(input int p, input int n);
    case (p)
      0:       return 8'(n) ^ 8'h5A;
      1:       return 8'hFF - 8'(n);
      2:       return 8'($urandom);
      default: return 8'h03;
    endcase
  endfunction

  // State memory: acks each held request after a random delay in [ack_lo, ack_hi].
  initial begin
    int wait_cnt, ack_dly;
    wait_cnt = 0;
    ack_dly  = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        mem_ack  = 1'b0;
        wait_cnt = 0;
        ack_dly  = $urandom_range(ack_hi, ack_lo);
      end else if (mem_ack) begin
        mem_ack = 1'b0;
      end else if ((mem_we || mem_re) && int'(mem_addr) != hold_addr) begin
        if (wait_cnt >= ack_dly) begin
          mem_ack  = 1'b1;
          wait_cnt = 0;
          ack_dly  = $urandom_range(ack_hi, ack_lo);
          if (mem_we) begin
            mem[mem_addr] = mem_wdat;
            wr_log.push_back({mem_addr, mem_wdat});
          end else begin
            mem_rdat = mem[mem_addr];
            rd_log.push_back(mem_addr);
          end
        end else begin
          wait_cnt++;
        end
      end
    end
  end

  // Mapper: captures a byte at the end of each ss_we burst; burst shape is checked here.
  initial begin
    logic       prev_we;
    logic [7:0] b_addr, b_dat;
    int         b_len;
    prev_we = 1'b0;
    b_addr  = 8'd0;
    b_dat   = 8'd0;
    b_len   = 0;
    forever begin
      @(negedge clk);
      if (mem_we || mem_re) check("we_re_excl", 32'(mem_we & mem_re), 32'd0);
      if (ss_we) begin
        check("we_in_act", 32'(ss_act), 32'd1);
        if (!prev_we) begin
          b_addr = ss_addr;
          b_dat  = ss_wdat;
          b_len  = 0;
        end else if (ss_addr !== b_addr || ss_wdat !== b_dat) begin
          check("we_hold_stable", {ss_addr, ss_wdat}, {b_addr, b_dat});
        end
        b_len++;
      end else if (prev_we && !rst) begin
        check("we_len", 32'(b_len), 32'(WE_HOLD));
        check("wdat_after_hold", 32'(ss_wdat), 32'(b_dat));
        map_state[b_addr] = b_dat;
        map_log.push_back({1'b0, b_addr, b_dat});
      end
      prev_we = ss_we;
    end
  end

  task automatic run_xfer(input vec_t v, input string tag);
    logic [7:0] s;
    bit         got_done, injected;
    int         bad;
    wr_log.delete(); rd_log.delete(); map_log.delete();
    exp_q.delete(); exp_m.delete(); exp_rd.delete();
    s = 8'd0;
    if (v.do_save) begin
      for (int n = 0; n < SS_LEN; n++) begin
        exp_q.push_back({1'b0, 8'(n), map_state[n]});
        s = s + map_state[n];
      end
      if (CHK_ON) exp_q.push_back({9'h100, s});
    end else begin
      for (int n = 0; n < SS_LEN; n++) begin
        exp_rd.push_back(9'(n));
        exp_m.push_back({1'b0, 8'(n), mem[n]});
      end
      if (CHK_ON) exp_rd.push_back(9'h100);
    end
    ack_lo = v.ack_lo;
    ack_hi = v.ack_hi;
    @(negedge clk);
    save_req = v.do_save;
    load_req = v.do_load;
    @(negedge clk);
    save_req = 1'b0;
    load_req = 1'b0;
    check({tag, " busy_rise"}, 32'(busy), 32'd1);
    check({tag, " act_rise"}, 32'(ss_act), 32'd1);
    got_done = 1'b0;
    injected = 1'b0;
    for (int c = 0; c < 5000 && !got_done; c++) begin
      @(negedge clk);
      load_req = 1'b0;
      if (v.inject >= 0 && !injected && mem_we && int'(mem_addr) == v.inject) begin
        load_req = 1'b1;
        injected = 1'b1;
      end
      if (done) begin
        got_done = 1'b1;
        check({tag, " busy_at_done"}, 32'(busy), 32'd0);
        check({tag, " act_at_done"}, 32'(ss_act), 32'd0);
      end
    end
    load_req = 1'b0;
    check({tag, " done_seen"}, 32'(got_done), 32'd1);
    @(negedge clk);
    check({tag, " done_single"}, 32'(done), 32'd0);
    repeat (3) @(negedge clk);
    check({tag, " idle_after"}, {30'd0, busy, ss_act}, 32'd0);
    check({tag, " chk_err"}, 32'(chk_err), 32'(v.exp_chk));
    check({tag, " wr_count"}, 32'(wr_log.size()), 32'(exp_q.size()));
    check({tag, " rd_count"}, 32'(rd_log.size()), 32'(exp_rd.size()));
    check({tag, " map_count"}, 32'(map_log.size()), 32'(exp_m.size()));
    for (int i = 0; i < exp_q.size() && i < wr_log.size(); i++)
      check($sformatf("%s wr[%0d]", tag, i), 32'(wr_log[i]), 32'(exp_q[i]));
    for (int i = 0; i < exp_rd.size() && i < rd_log.size(); i++)
      check($sformatf("%s rd[%0d]", tag, i), 32'(rd_log[i]), 32'(exp_rd[i]));
    for (int i = 0; i < exp_m.size() && i < map_log.size(); i++)
      check($sformatf("%s map[%0d]", tag, i), 32'(map_log[i]), 32'(exp_m[i]));
    if (!v.do_save) begin
      bad = 0;
      for (int n = 0; n < SS_LEN; n++) if (map_state[n] !== mem[n]) bad++;
      check({tag, " map_equals_mem"}, 32'(bad), 32'd0);
    end
  endtask

  initial begin
    vec_t rv;
    logic [7:0] s;
    bit found;
    // {save, load, pattern, ack_lo, ack_hi, inject, corrupt, exp_chk}
    vecs[0] = '{1'b1, 1'b0, 0, 2, 2, -1, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 1, 0, 3, -1, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 2, 0, 3, 10, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 3, 2, 2, -1, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 3, 0, 2, -1, 1'b1, CHK_ON};
    vecs[5] = '{1'b0, 1'b1, 3, 0, 2, -1, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 2, 0, 0, -1, 1'b0, 1'b0};
    for (int i = 0; i < 256; i++) map_state[i] = 8'd0;
    for (int i = 0; i < 512; i++) mem[i] = 8'd0;

    repeat (3) @(negedge clk);
    check("rst_outputs", {26'd0, busy, done, ss_act, ss_we, mem_we, mem_re}, 32'd0);
    check("rst_addrs", {15'd0, ss_addr, mem_addr}, 32'd0);
    check("rst_chk_err", 32'(chk_err), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      if (vecs[i].do_save) begin
        for (int n = 0; n < 256; n++) map_state[n] = pat(vecs[i].pattern, n);
      end else begin
        for (int n = 0; n < SS_LEN; n++) mem[n] = pat(vecs[i].pattern, n);
        if (vecs[i].pattern != 3) begin
          s = 8'd0;
          for (int n = 0; n < SS_LEN; n++) s = s + mem[n];
          mem[256] = s;
        end
        if (vecs[i].corrupt) mem[5] = 8'h04;
      end
      run_xfer(vecs[i], $sformatf("v%0d", i));
    end

    // Reset while the load waits for mem_ack at index 37, then a fresh save from index 0.
    for (int n = 0; n < SS_LEN; n++) mem[n] = 8'($urandom);
    ack_lo = 0;
    ack_hi = 1;
    hold_addr = 37;
    @(negedge clk);
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 5000 && !found; c++) begin
      if (mem_re && mem_addr == 9'd37) found = 1'b1;
      else @(negedge clk);
    end
    check("rst_mid_reach37", 32'(found), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_outputs", {27'd0, ss_act, ss_we, mem_re, mem_we, busy}, 32'd0);
    rst = 1'b0;
    hold_addr = -1;
    for (int n = 0; n < 256; n++) map_state[n] = pat(2, n);
    rv = '{1'b1, 1'b0, 2, 0, 2, -1, 1'b0, 1'b0};
    run_xfer(rv, "after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/map_ss_seq.md
Name: map_ss_seq

Overview:
- Save-state sequencer directly upstream of each mapper's save-state port.
- Drives ss_act/ss_we/ss_addr/write-data into the mapper and consumes the mapper's ss_rdat.
- On save, walks mapper state bytes 0..SS_LEN-1 into external state memory. On load, walks memory back into the mapper.
- Handshakes with state memory via req/ack. Holds each mapper write long enough for the mapper's m2-edge capture.

Parameters:
- SS_LEN, 128: number of state bytes transferred, at addresses 0..SS_LEN-1. Must be ≤256.
- WE_HOLD, 4: clk cycles ss_we is held per restored byte. Must be ≥1.
- RD_SETTLE, 1: clk cycles between an ss_addr change and sampling ss_rdat. Must be ≥1.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- save_req  in  1  one-cycle pulse; start save
- load_req  in  1  one-cycle pulse; start load
- busy  out  1  high from accept until done
- done  out  1  one-cycle pulse at end of transfer
- ss_act  out  1  mapper save-state mode
- ss_we  out  1  mapper state write strobe
- ss_addr  out  8  mapper state byte index
- ss_wdat  out  8  byte to mapper; muxed onto cpu_dat downstream while ss_act
- ss_rdat  in  8  mapper state byte readback
- mem_addr  out  9  state memory address
- mem_wdat  out  8  state memory write data
- mem_we  out  1  write request; held until mem_ack
- mem_re  out  1  read request; held until mem_ack
- mem_rdat  in  8  read data; valid in the mem_ack cycle
- mem_ack  in  1  one-cycle completion from state memory
- chk_err  out  1  checksum mismatch; meaningful only with SS_CHKSUM_EN

Behaviour:
- Reset: every output is 0, the FSM is in IDLE, and the index is 0.
- Reset mid-transfer: all outputs return to 0 at the next clk edge. Any pending mem request is abandoned.
- IDLE:
  - save_req → S_SET.
  - load_req → L_REQ.
  - Both in the same cycle → save wins.
  - Requests while busy are ignored, not queued.
- busy and ss_act rise on the cycle after accept and stay high through the last state before DONE.
- Save path:
  - S_SET: ss_addr=idx; wait RD_SETTLE cycles.
  - S_WR: latch ss_rdat into mem_wdat; assert mem_we with mem_addr={1'b0,idx} until mem_ack.
  - NEXT after mem_ack.
- Load path:
  - L_REQ: mem_re with mem_addr={1'b0,idx} until mem_ack; capture mem_rdat into ss_wdat at ack.
  - L_WR: ss_addr=idx; ss_we high for exactly WE_HOLD cycles; ss_wdat stable for the whole hold and one cycle after.
  - L_GAP: one cycle with ss_we=0, ss_act=1.
  - NEXT.
- NEXT:
  - If idx==SS_LEN-1 → DONE.
  - Otherwise idx+1 and return to S_SET or L_REQ.
  - idx is 8-bit and never wraps past SS_LEN-1.
- DONE: done=1 for one cycle; busy=0, ss_act=0 in the same cycle; idx cleared; → IDLE.
- mem_ack while neither mem_we nor mem_re is asserted is ignored.
- mem_we and mem_re are never high together.
- ss_we is high only in L_WR.
- mem_addr[8] is 0 except for the checksum access.

Optional Feature:
- Macro: SS_CHKSUM_EN.
- When defined:
  - An 8-bit wrapping sum accumulates every byte transferred (ss_rdat on save, mem_rdat on load).
  - Save: after byte SS_LEN-1, extra state S_CHK writes the sum to mem_addr 9'h100, then DONE.
  - Load: after the last byte, L_CHK reads 9'h100. chk_err is set if the read value ≠ sum, then DONE.
  - chk_err is cleared on reset or on the next accepted request, and holds otherwise.
- When undefined: no extra access; chk_err tied to 0; DONE follows the last byte directly.

Test Plan:
- Save with a mapper model returning ss_rdat=ss_addr^8'h5A and mem_ack 2 cycles after each request → 128 writes, mem[n]=n^8'h5A, a single done pulse, busy low after.
- Load with mem[n]=8'hFF-n → for each n, ss_we high exactly 4 cycles with ss_addr=n and ss_wdat=8'hFF-n; model state equals the memory contents at done.
- save_req and load_req in the same cycle → save runs; load_req pulsed at index 10 mid-save → ignored, no extra transfers.
- rst asserted while waiting for mem_ack at index 37 of a load → next cycle ss_act=ss_we=mem_re=busy=0. A subsequent save starts at index 0.
- SS_CHKSUM_EN, save with all bytes 8'h03 → mem[9'h100]=8'h80. Load with one byte corrupted to 8'h04 → chk_err=1 at done; clean load → chk_err=0.
- SS_LEN=4, WE_HOLD=1, mem_ack immediate → exactly 4 transfers; idx stops at 3; done pulses; no access to address 4.
